// File: rtl/adder_disp_pkg.sv
// adder_disp_pkg: shared types, segment codes and the double-dabble nibble correction
package adder_disp_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, CONV = 1'b1} state_t;
  localparam int CONV_ITERS = 5;
  localparam int BCD_W = 8;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: BCD nibble to active-low {dp,g,f,e,d,c,b,a}, non-decimal nibbles blank
module seg7_decoder
  import adder_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/adder_result_display.sv
// adder_result_display: captures the adder sum, converts to BCD and scans a 2-digit 7-seg display
module adder_result_display
  import adder_disp_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       sum_i,
  input  logic             sum_valid_i,
  output logic             busy_o,
  output logic [BCD_W-1:0] bcd_o,
  output logic             bcd_valid_o,
  output logic [7:0]       seg_o,
  output logic [1:0]       an_o
);
  localparam int CW = SCAN_DIV > 2 ? $clog2(SCAN_DIV) : 1;
  state_t        state;
  logic [2:0]    it;
  logic [12:0]   sr;
  logic [12:0]   sr_adj;
  logic [CW-1:0] scan_cnt;
  logic          digit_sel;
  logic          blank;
  logic [3:0]    digit;
  logic [7:0]    seg_code;
  // register layout is {tens, ones, binary}; only the BCD nibbles get corrected
  assign sr_adj = {dd_adj(sr[12:9]), dd_adj(sr[8:5]), sr[4:0]};
  assign busy_o = state == CONV;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      it <= '0;
      sr <= '0;
      bcd_o <= '0;
      bcd_valid_o <= 1'b0;
    end else begin
      bcd_valid_o <= 1'b0;
      if (state == IDLE && sum_valid_i) begin
        sr <= {8'h00, sum_i};
        it <= '0;
        state <= CONV;
      end else if (state == CONV) begin
        sr <= {sr_adj[11:0], 1'b0};
        it <= it + 3'd1;
        if (it == 3'(CONV_ITERS - 1)) begin
          bcd_o <= sr_adj[11:4];
          bcd_valid_o <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      digit_sel <= 1'b0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      digit_sel <= ~digit_sel;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end
  assign digit = digit_sel ? bcd_o[7:4] : bcd_o[3:0];
  assign blank = digit_sel && bcd_o[7:4] == 4'd0;
  seg7_decoder u_dec (
    .bcd(digit),
    .seg(seg_code)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_o <= 2'b10;
      seg_o <= SEG_0;
    end else begin
      an_o <= !digit_sel ? 2'b10 : blank ? 2'b11 : 2'b01;
      seg_o <= blank ? SEG_BLANK : seg_code;
    end
  end
endmodule

// File: tb/tb_adder_result_display.sv
// tb_adder_result_display: scoreboard bench with directed vectors for the result display stage
module tb_adder_result_display;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] sum_i = '0;
  logic       sum_valid_i = 1'b0;
  logic       busy_o;
  logic [7:0] bcd_o;
  logic       bcd_valid_o;
  logic [7:0] seg_o;
  logic [1:0] an_o;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  adder_result_display #(.SCAN_DIV(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sum_i(sum_i),
    .sum_valid_i(sum_valid_i),
    .busy_o(busy_o),
    .bcd_o(bcd_o),
    .bcd_valid_o(bcd_valid_o),
    .seg_o(seg_o),
    .an_o(an_o)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && bcd_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {24'h0, bcd_o}, 32'hFFFF_FFFF);
      end else begin
        chk("scoreboard_bcd", {24'h0, bcd_o}, {24'h0, exp_q.pop_front()});
      end
    end
  end
  task automatic send(input int v, input bit push);
    @(negedge clk);
    sum_i = 5'(v);
    sum_valid_i = 1'b1;
    if (push) exp_q.push_back(to_bcd(v));
    @(negedge clk);
    sum_valid_i = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", {31'h0, busy_o}, 32'h0);
    @(negedge clk);
  endtask
  task automatic wait_an(input logic [1:0] t);
    int n = 0;
    while (an_o !== t && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_an", {30'h0, an_o}, {30'h0, t});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_bcd", {24'h0, bcd_o}, 32'h0);
    chk("rst_valid", {31'h0, bcd_valid_o}, 32'h0);
    chk("rst_an", {30'h0, an_o}, 32'h2);
    chk("rst_seg", {24'h0, seg_o}, 32'hC0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("scan_an", {30'h0, an_o}, ((i - 1) / 4) % 2 ? 32'h3 : 32'h2);
      chk("scan_seg", {24'h0, seg_o}, ((i - 1) / 4) % 2 ? 32'hFF : 32'hC0);
    end
    // conversion of 13 with cycle-exact busy window
    @(negedge clk);
    sum_i = 5'd13;
    sum_valid_i = 1'b1;
    exp_q.push_back(8'h13);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sum_valid_i = 1'b0;
      chk("busy_13", {31'h0, busy_o}, 32'h1);
    end
    @(negedge clk);
    chk("busy_13_done", {31'h0, busy_o}, 32'h0);
    chk("valid_13", {31'h0, bcd_valid_o}, 32'h1);
    chk("bcd_13", {24'h0, bcd_o}, 32'h13);
    @(negedge clk);
    chk("valid_13_single", {31'h0, bcd_valid_o}, 32'h0);
    wait_an(2'b01);
    chk("disp13_tens", {24'h0, seg_o}, 32'hF9);
    wait_an(2'b10);
    chk("disp13_ones", {24'h0, seg_o}, 32'hB0);
    send(31, 1'b1);
    wait_idle();
    chk("bcd_31", {24'h0, bcd_o}, 32'h31);
    send(9, 1'b1);
    wait_idle();
    chk("bcd_9", {24'h0, bcd_o}, 32'h09);
    wait_an(2'b10);
    wait_an(2'b11);
    chk("disp9_blank", {24'h0, seg_o}, 32'hFF);
    wait_an(2'b10);
    chk("disp9_ones", {24'h0, seg_o}, 32'h90);
    send(10, 1'b1);
    wait_idle();
    chk("bcd_10", {24'h0, bcd_o}, 32'h10);
    wait_an(2'b01);
    chk("disp10_tens", {24'h0, seg_o}, 32'hF9);
    wait_an(2'b10);
    chk("disp10_ones", {24'h0, seg_o}, 32'hC0);
    for (int v = 0; v < 32; v++) begin
      send(v, 1'b1);
      wait_idle();
    end
    // strobes at N+2 and N+5 are dropped, the one at N+6 is taken
    @(negedge clk);
    sum_i = 5'd20;
    sum_valid_i = 1'b1;
    exp_q.push_back(8'h20);
    @(negedge clk);
    sum_valid_i = 1'b0;
    @(negedge clk);
    sum_i = 5'd7;
    sum_valid_i = 1'b1;
    @(negedge clk);
    sum_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sum_valid_i = 1'b1;
    @(negedge clk);
    chk("busy_drop_20", {24'h0, bcd_o}, 32'h20);
    exp_q.push_back(8'h07);
    @(negedge clk);
    sum_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_late_pending", {31'h0, bcd_valid_o}, 32'h0);
    @(negedge clk);
    chk("busy_late_valid", {31'h0, bcd_valid_o}, 32'h1);
    chk("busy_late_bcd", {24'h0, bcd_o}, 32'h07);
    repeat (2) @(negedge clk);
    send(17, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_bcd", {24'h0, bcd_o}, 32'h0);
    chk("midrst_busy", {31'h0, busy_o}, 32'h0);
    chk("midrst_valid", {31'h0, bcd_valid_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_hold", {24'h0, bcd_o}, 32'h0);
    send(25, 1'b1);
    wait_idle();
    chk("bcd_25", {24'h0, bcd_o}, 32'h25);
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
